// File: rtl/blur_out_packer.sv
// blur_out_packer
// Takes the 3x3 blur stage's 11-bit R/G/B outputs and the raw CCD write strobe.
// Delays the strobe to line up with the blur pipeline and tracks the pixel's X/Y.
// Optionally zeroes the one-pixel frame border and clamps each channel to 10 bits.
// Packs the result into the 30-bit {R,G,B} word for the SDRAM write FIFO.
module blur_out_packer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LATENCY  = 2
) (
  input  logic        CCD_FIFO_WRCLK,
  input  logic        iRST_N,
  input  logic        CCD_FIFO_WE,
  input  logic        iFVAL,
  input  logic        iMaskEn,
  input  logic [10:0] iRed,
  input  logic [10:0] iGreen,
  input  logic [10:0] iBlue,
  output logic [29:0] oFIFO_DATA,
  output logic        oFIFO_WE,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic        oFrameDone
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [29:0]        data_q, data_d;
  logic               we_q, we_d;
  logic [9:0]         ox_q, ox_d;
  logic [8:0]         oy_q, oy_d;
  logic               done_q, done_d;

  logic               vld_d;
  logic [9:0]         red_sat, green_sat, blue_sat;
  logic               is_border;

  assign vld_d = vld_sr_q[LATENCY-1];

  // Anything at or above 1024 has bit 10 set, so that bit alone selects the clamp.
  assign red_sat   = iRed[10]   ? 10'h3FF : iRed[9:0];
  assign green_sat = iGreen[10] ? 10'h3FF : iGreen[9:0];
  assign blue_sat  = iBlue[10]  ? 10'h3FF : iBlue[9:0];

  // The 3x3 window reaches outside the frame on the outermost ring of pixels.
  assign is_border = (x_q == 10'd0) || (x_q == X_LAST) ||
                     (y_q == 9'd0)  || (y_q == Y_LAST);

  // Next-state for the valid pipe, position counters and capture registers.
  always_comb begin
    vld_sr_d = vld_sr_q;
    x_d      = x_q;
    y_d      = y_q;
    data_d   = data_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    we_d     = 1'b0;
    done_d   = 1'b0;

    if (!iFVAL) begin
      // Frame gap: drop whatever is in flight and restart at the origin.
      vld_sr_d = '0;
      x_d      = 10'd0;
      y_d      = 9'd0;
    end else begin
      vld_sr_d[0] = CCD_FIFO_WE;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr_d[i] = vld_sr_q[i-1];
      end

      if (vld_d) begin
        we_d = 1'b1;
        ox_d = x_q;
        oy_d = y_q;
        if (iMaskEn && is_border) begin
          data_d = 30'h0;
        end else begin
          data_d = {red_sat, green_sat, blue_sat};
        end

        if (x_q == X_LAST) begin
          x_d = 10'd0;
          if (y_q == Y_LAST) begin
            y_d    = 9'd0;
            done_d = 1'b1;
          end else begin
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CCD_FIFO_WRCLK) begin
    if (!iRST_N) begin
      vld_sr_q <= '0;
      x_q      <= 10'd0;
      y_q      <= 9'd0;
      data_q   <= 30'h0;
      we_q     <= 1'b0;
      ox_q     <= 10'd0;
      oy_q     <= 9'd0;
      done_q   <= 1'b0;
    end else begin
      vld_sr_q <= vld_sr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      done_q   <= done_d;
    end
  end

  assign oFIFO_DATA = data_q;
  assign oFIFO_WE   = we_q;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oFrameDone = done_q;

endmodule

// File: tb/tb_blur_out_packer.sv
// Testbench for blur_out_packer on a small 4x3 frame.
// Expected pixels are queued as stimulus is driven and compared as strobes appear.
module tb_blur_out_packer;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int LAT = 2;

  logic        clk;
  logic        iRST_N;
  logic        CCD_FIFO_WE;
  logic        iFVAL;
  logic        iMaskEn;
  logic [10:0] iRed, iGreen, iBlue;
  logic [29:0] oFIFO_DATA;
  logic        oFIFO_WE;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic        oFrameDone;

  typedef struct {
    logic [29:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        done;
  } expT;

  expT expQ[$];
  expT monE;

  int assertCount = 0;
  int failCount   = 0;
  int strobeCount = 0;
  int doneCount   = 0;
  int nonzeroCount = 0;

  int modelX = 0;
  int modelY = 0;

  logic [10:0] histR [0:LAT];
  logic [10:0] histG [0:LAT];
  logic [10:0] histB [0:LAT];

  blur_out_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .LATENCY(LAT)) dut (
    .CCD_FIFO_WRCLK(clk),
    .iRST_N(iRST_N),
    .CCD_FIFO_WE(CCD_FIFO_WE),
    .iFVAL(iFVAL),
    .iMaskEn(iMaskEn),
    .iRed(iRed),
    .iGreen(iGreen),
    .iBlue(iBlue),
    .oFIFO_DATA(oFIFO_DATA),
    .oFIFO_WE(oFIFO_WE),
    .oX(oX),
    .oY(oY),
    .oFrameDone(oFrameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] sat10(input logic [10:0] v);
    return (v > 11'd1023) ? 10'h3FF : v[9:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, {2'b0, oFIFO_DATA}, 32'h0);
    checkOutput({tag, "_we"},   {31'b0, oFIFO_WE},  32'h0);
    checkOutput({tag, "_x"},    {22'b0, oX},        32'h0);
    checkOutput({tag, "_y"},    {23'b0, oY},        32'h0);
    checkOutput({tag, "_done"}, {31'b0, oFrameDone}, 32'h0);
  endtask

  // One clock cycle of stimulus; r/g/b belong to this cycle's strobe and
  // reach the DUT LAT cycles later, the way the blur stage would deliver them.
  task automatic applyStimulus(input logic rstN, input logic we, input logic fval,
                               input logic mask, input logic [10:0] r,
                               input logic [10:0] g, input logic [10:0] b);
    expT e;
    logic border;
    @(negedge clk);
    if (!rstN || !fval) begin
      expQ.delete();
      modelX = 0;
      modelY = 0;
    end else if (we) begin
      border = (modelX == 0) || (modelX == H-1) || (modelY == 0) || (modelY == V-1);
      e.data = (mask && border) ? 30'h0 : {sat10(r), sat10(g), sat10(b)};
      e.x    = 10'(modelX);
      e.y    = 9'(modelY);
      e.done = (modelX == H-1) && (modelY == V-1);
      expQ.push_back(e);
      if (modelX == H-1) begin
        modelX = 0;
        modelY = (modelY == V-1) ? 0 : modelY + 1;
      end else begin
        modelX = modelX + 1;
      end
    end
    for (int i = LAT; i > 0; i--) begin
      histR[i] = histR[i-1];
      histG[i] = histG[i-1];
      histB[i] = histB[i-1];
    end
    histR[0] = r;
    histG[0] = g;
    histB[0] = b;
    iRST_N      = rstN;
    CCD_FIFO_WE = we;
    iFVAL       = fval;
    iMaskEn     = mask;
    iRed        = histR[LAT];
    iGreen      = histG[LAT];
    iBlue       = histB[LAT];
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every strobe must match the next queued pixel.
  always @(posedge clk) begin
    #1;
    if (oFIFO_WE === 1'b1) begin
      strobeCount++;
      if (oFrameDone === 1'b1) doneCount++;
      if (oFIFO_DATA !== 30'h0) nonzeroCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("pix_data", {2'b0, oFIFO_DATA}, {2'b0, monE.data});
        checkOutput("pix_x",    {22'b0, oX},        {22'b0, monE.x});
        checkOutput("pix_y",    {23'b0, oY},        {23'b0, monE.y});
        checkOutput("pix_done", {31'b0, oFrameDone}, {31'b0, monE.done});
      end
    end else if (oFIFO_WE === 1'b0) begin
      checkOutput("done_without_we", {31'b0, oFrameDone}, 32'd0);
    end
  end

  initial begin
    iRST_N = 1'b0; CCD_FIFO_WE = 1'b0; iFVAL = 1'b0; iMaskEn = 1'b0;
    iRed = '0; iGreen = '0; iBlue = '0;
    for (int i = 0; i <= LAT; i++) begin
      histR[i] = '0; histG[i] = '0; histB[i] = '0;
    end

    // Test 1: reset held with active strobe, then latency, back-to-back and overrun.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h123, 11'h456, 11'h789);
      checkAllZero("t1_reset");
    end
    strobeCount = 0; doneCount = 0;
    for (int i = 1; i <= LAT + 1; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'($urandom_range(0, 2047)),
                    11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
      checkOutput("t1_latency", {31'b0, oFIFO_WE}, (i == LAT + 1) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'($urandom_range(0, 2047)),
                    11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
      checkOutput("t1_b2b_we", {31'b0, oFIFO_WE}, 32'd1);
    end
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    checkOutput("t1_strobes", 32'(strobeCount), 32'd15);
    checkOutput("t1_frame_done", 32'(doneCount), 32'd1);

    // Test 2: single pulse, packing at (0,0).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    strobeCount = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'h155, 11'h0AA, 11'h3FF);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    checkOutput("t2_strobes", 32'(strobeCount), 32'd1);
    checkOutput("t2_data_hold", {2'b0, oFIFO_DATA}, 32'h1552ABFF);

    // Test 3: saturation on the next pixel.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'h7FF, 11'h400, 11'h3FF);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    checkOutput("t3_strobes", 32'(strobeCount), 32'd2);
    checkOutput("t3_data_hold", {2'b0, oFIFO_DATA}, 32'h3FFFFFFF);

    // Test 4: border masking over a full frame of constant input.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    strobeCount = 0; doneCount = 0; nonzeroCount = 0;
    for (int i = 0; i < H * V; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h100, 11'h100, 11'h100);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    checkOutput("t4_strobes", 32'(strobeCount), 32'd12);
    checkOutput("t4_nonzero", 32'(nonzeroCount), 32'd2);
    checkOutput("t4_frame_done", 32'(doneCount), 32'd1);
    checkOutput("t4_last_x", {22'b0, oX}, 32'd3);
    checkOutput("t4_last_y", {23'b0, oY}, 32'd2);

    // Test 5: frame gap with two pixels still in flight.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    strobeCount = 0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'(i + 1), 11'(i + 20), 11'(i + 40));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkOutput("t5_strobes", 32'(strobeCount), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'h2A, 11'h2B, 11'h2C);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    checkOutput("t5_restart_strobes", 32'(strobeCount), 32'd6);
    checkOutput("t5_restart_x", {22'b0, oX}, 32'd0);
    checkOutput("t5_restart_y", {23'b0, oY}, 32'd0);

    // Test 6: reset mid-frame around pixel (2,1) with the strobe continuous.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    strobeCount = 0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'(i + 100), 11'(i + 200), 11'(i + 300));
    checkOutput("t6_pre_reset_strobes", 32'(strobeCount), 32'd5);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'h3F0, 11'h3F1, 11'h3F2);
      checkAllZero("t6_reset");
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 11'(i + 500), 11'(i + 600), 11'(i + 700));
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    checkOutput("t6_strobes", 32'(strobeCount), 32'd10);
    checkOutput("t6_last_x", {22'b0, oX}, 32'd0);
    checkOutput("t6_last_y", {23'b0, oY}, 32'd1);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
